// File: rtl/ldtu_bsl_pkg.sv
// Shared types and constants for the LiTe-DTU baseline calibration block.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package ldtu_bsl_pkg;

  localparam int Nbits_12 = 12;  // raw ADC sample width
  localparam int Nbits_8  = 8;   // baseline value width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } bsl_state_t;

  typedef enum logic {
    G01 = 1'b0,
    G10 = 1'b1
  } gsel_t;

  // The accumulator holds 2^nsamp_log2 full-scale samples without overflow.
  function automatic int acc_width(input int nsamp_log2);
    return Nbits_12 + nsamp_log2;
  endfunction

  // Per-gain bit position inside cal_err.
  function automatic logic [1:0] gsel_bit(input gsel_t g);
    return (g == G10) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ldtu_bsl_accum.sv
// Sample accumulator with sample counter and no-data timeout counter.
// Latency: sum reflects a sample one cycle after it is accepted; count_full/timed_out are same-cycle flags.
// Backpressure: none; every sample_valid cycle is accepted.
//
// Ports: CLK, rst (sync, active-high), clear (zero all counters),
//        sample_in/sample_valid (sample to add), sum (running total),
//        count_full (this sample is the last of the block), timed_out (this idle cycle is the terminal one).
module ldtu_bsl_accum
  import ldtu_bsl_pkg::*;
#(
  parameter int  NSAMP_LOG2 = 6,
  parameter int  TIMEOUT    = 1023,
  localparam int AW         = acc_width(NSAMP_LOG2),
  localparam int TW         = $clog2(TIMEOUT + 1)
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                clear,
  input  logic [Nbits_12-1:0] sample_in,
  input  logic                sample_valid,
  output logic [AW-1:0]       sum,
  output logic                count_full,
  output logic                timed_out
);

  logic [NSAMP_LOG2-1:0] cnt;
  logic [TW-1:0]         tcnt;

  // Both flags describe the current cycle so the FSM can leave ACC on the
  // very edge that accepts the last sample / closes the last idle cycle.
  assign count_full = sample_valid && (cnt == '1);
  assign timed_out  = !sample_valid && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (rst || clear) begin
      sum  <= '0;
      cnt  <= '0;
      tcnt <= '0;
    end else if (sample_valid) begin
      sum  <= sum + AW'(sample_in);
      cnt  <= cnt + 1'b1;
      tcnt <= '0;
    end else if (tcnt != '1) begin
      // Saturate so the counter can never wrap back below the terminal count.
      tcnt <= tcnt + 1'b1;
    end
  end

endmodule

// File: rtl/ldtu_bsl_calib.sv
// Baseline calibration controller: averages 2^NSAMP_LOG2 samples per gain (g01 then g10), subtracts margin, saturates to 8 bits.
// Latency: with continuous valid, cal_done N+2 cycles (one gain) or 2N+3 cycles (both gains) after cal_start.
// Backpressure: none; samples are taken whenever the selected valid is high, cal_start while busy is dropped.
//
// Ports: CLK, rst (sync, active-high); cal_start/cal_mask/margin/shift_gain_10 (command, latched on start);
//        DATA12_g01/valid_g01, DATA12_g10/valid_g10 (raw samples);
//        BSL_VAL_g01/BSL_VAL_g10 (baselines), cal_busy, cal_done (pulse), cal_err (sticky per gain).
module ldtu_bsl_calib
  import ldtu_bsl_pkg::*;
#(
  parameter int NSAMP_LOG2 = 6,
  parameter int TIMEOUT    = 1023
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                cal_start,
  input  logic [1:0]          cal_mask,
  input  logic [3:0]          margin,
  input  logic [1:0]          shift_gain_10,
  input  logic [Nbits_12-1:0] DATA12_g01,
  input  logic                valid_g01,
  input  logic [Nbits_12-1:0] DATA12_g10,
  input  logic                valid_g10,
  output logic [Nbits_8-1:0]  BSL_VAL_g01,
  output logic [Nbits_8-1:0]  BSL_VAL_g10,
  output logic                cal_busy,
  output logic                cal_done,
  output logic [1:0]          cal_err
);

  localparam int AW = acc_width(NSAMP_LOG2);

  bsl_state_t          state;
  gsel_t               gsel;
  logic [1:0]          mask_q;
  logic [3:0]          margin_q;
  logic [1:0]          shift_q;

  logic [Nbits_12-1:0] sel_dat;
  logic                sel_vld;
  logic                acc_clear;
  logic [AW-1:0]       sum;
  logic                count_full;
  logic                timed_out;

  logic [AW-1:0]       mean_full;
  logic [AW-1:0]       diff;
  logic                below;
  logic                sat;
  logic [Nbits_8-1:0]  result;
  logic                more_g10;

  // Sample source follows the gain select; g10 gets the same shift as the datapath.
  always_comb begin
    sel_dat = DATA12_g01;
    sel_vld = 1'b0;
    if (gsel == G10) begin
      sel_dat = DATA12_g10 >> shift_q;
    end
    if (state == ACC) begin
      sel_vld = (gsel == G10) ? valid_g10 : valid_g01;
    end
  end

  // Zero the accumulator on every cycle that is not an active ACC cycle and on
  // the timeout cycle, so each ACC entry starts clean. STORE still sees the
  // full sum because the clear only lands at the end of that cycle.
  assign acc_clear = (state != ACC) || timed_out;

  ldtu_bsl_accum #(
    .NSAMP_LOG2 (NSAMP_LOG2),
    .TIMEOUT    (TIMEOUT)
  ) u_accum (
    .CLK          (CLK),
    .rst          (rst),
    .clear        (acc_clear),
    .sample_in    (sel_dat),
    .sample_valid (sel_vld),
    .sum          (sum),
    .count_full   (count_full),
    .timed_out    (timed_out)
  );

  // Mean, margin subtraction and 8-bit saturation, evaluated in STORE.
  always_comb begin
    mean_full = sum >> NSAMP_LOG2;
    diff      = mean_full - AW'(margin_q);
    below     = (mean_full <= AW'(margin_q));
    sat       = !below && (diff > AW'((1 << Nbits_8) - 1));
    result    = '0;
    if (sat) begin
      result = '1;
    end else if (!below) begin
      result = diff[Nbits_8-1:0];
    end
  end

  assign more_g10 = (gsel == G01) && mask_q[1];

  always_ff @(posedge CLK) begin
    if (rst) begin
      state       <= IDLE;
      gsel        <= G01;
      mask_q      <= '0;
      margin_q    <= '0;
      shift_q     <= '0;
      BSL_VAL_g01 <= '0;
      BSL_VAL_g10 <= '0;
      cal_busy    <= 1'b0;
      cal_done    <= 1'b0;
      cal_err     <= '0;
    end else begin
      cal_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cal_start) begin
            mask_q   <= cal_mask;
            margin_q <= margin;
            shift_q  <= shift_gain_10;
            cal_err  <= '0;
            cal_busy <= 1'b1;
            if (cal_mask == 2'b00) begin
              state    <= DONE;
              cal_done <= 1'b1;
            end else begin
              state <= ACC;
              gsel  <= cal_mask[0] ? G01 : G10;
            end
          end
        end
        ACC: begin
          // count_full needs valid and timed_out needs !valid, so valid wins.
          if (count_full) begin
            state <= STORE;
          end else if (timed_out) begin
            cal_err <= cal_err | gsel_bit(gsel);
            if (more_g10) begin
              gsel <= G10;
            end else begin
              state    <= DONE;
              cal_done <= 1'b1;
            end
          end
        end
        STORE: begin
          if (gsel == G10) BSL_VAL_g10 <= result;
          else             BSL_VAL_g01 <= result;
          if (sat) cal_err <= cal_err | gsel_bit(gsel);
          if (more_g10) begin
            gsel  <= G10;
            state <= ACC;
          end else begin
            state    <= DONE;
            cal_done <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          cal_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldtu_bsl_calib.sv
// Testbench for ldtu_bsl_calib: per-calibration expectations queued at cal_start, checked on cal_done.
// Latency: n/a.
// Backpressure: n/a.
module tb_ldtu_bsl_calib;

  localparam int NL = 6;
  localparam int N  = 1 << NL;
  localparam int TO = 1023;

  logic        CLK = 1'b0;
  logic        rst;
  logic        cal_start;
  logic [1:0]  cal_mask;
  logic [3:0]  margin;
  logic [1:0]  shift_gain_10;
  logic [11:0] DATA12_g01;
  logic        valid_g01;
  logic [11:0] DATA12_g10;
  logic        valid_g10;
  logic [7:0]  BSL_VAL_g01;
  logic [7:0]  BSL_VAL_g10;
  logic        cal_busy;
  logic        cal_done;
  logic [1:0]  cal_err;

  always #5 CLK = ~CLK;

  ldtu_bsl_calib #(.NSAMP_LOG2(NL), .TIMEOUT(TO)) dut (
    .CLK           (CLK),
    .rst           (rst),
    .cal_start     (cal_start),
    .cal_mask      (cal_mask),
    .margin        (margin),
    .shift_gain_10 (shift_gain_10),
    .DATA12_g01    (DATA12_g01),
    .valid_g01     (valid_g01),
    .DATA12_g10    (DATA12_g10),
    .valid_g10     (valid_g10),
    .BSL_VAL_g01   (BSL_VAL_g01),
    .BSL_VAL_g10   (BSL_VAL_g10),
    .cal_busy      (cal_busy),
    .cal_done      (cal_done),
    .cal_err       (cal_err)
  );

  typedef struct {
    int dly;
    int b01;
    int b10;
    int err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   n_done = 0;

  // Stimulus pattern: g01 alternates a01/b01v per accepted sample, optionally
  // stopping after lim01 samples; g10 is a constant.
  int   a01 = 0, b01v = 0, lim01 = -1, sent01 = 0, v10val = 0;
  bit   en01 = 0, en10 = 0;
  bit   go = 0, go_track = 0;
  logic [1:0] go_mask = 0;
  int   go_mg = 0, go_sh = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int model_res(input int mean, input int mg);
    int r;
    r = mean - mg;
    if (r < 0)   r = 0;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    cal_start = 1'b0;
    if (go) begin
      cal_start     = 1'b1;
      cal_mask      = go_mask;
      margin        = go_mg[3:0];
      shift_gain_10 = go_sh[1:0];
      if (go_track) begin
        start_cyc = cyc;
        sent01    = 0;
      end
    end
    if (en01 && !(go && go_track) && (lim01 < 0 || sent01 < lim01)) begin
      valid_g01  = 1'b1;
      DATA12_g01 = 12'((sent01 % 2) ? b01v : a01);
      sent01++;
    end else begin
      valid_g01  = 1'b0;
      DATA12_g01 = 12'hFFF;
    end
    valid_g10  = en10 && !(go && go_track);
    DATA12_g10 = 12'(v10val);
    go = 1'b0;
  endtask

  task automatic kick(input logic [1:0] m, input int mg, input int sh, input bit track);
    go       = 1'b1;
    go_mask  = m;
    go_mg    = mg;
    go_sh    = sh;
    go_track = track;
    step();
  endtask

  task automatic push_exp(input int dly, input int b01, input int b10, input int err);
    exp_t e;
    e.dly = dly;
    e.b01 = b01;
    e.b10 = b10;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    check_eq({tag, "_wait"}, sb.size(), 0);
    step();
    step();
  endtask

  // Output monitor: samples on the falling edge, pops one expectation per cal_done.
  initial begin
    bit   prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge CLK);
      if (prev_done) check_eq("busy_after_done", cal_busy, 0);
      prev_done = (cal_done === 1'b1);
      if (cal_done === 1'b1) begin
        n_done++;
        if (sb.size() == 0) begin
          check_eq("unexpected_done", cal_done, 0);
        end else begin
          e = sb.pop_front();
          check_eq("done_cycle", cyc - start_cyc, e.dly);
          check_eq("bsl_g01", BSL_VAL_g01, e.b01);
          check_eq("bsl_g10", BSL_VAL_g10, e.b10);
          check_eq("cal_err", cal_err, e.err);
          check_eq("busy_at_done", cal_busy, 1);
        end
      end
    end
  end

  initial begin
    int done_before;
    rst           = 1'b1;
    cal_start     = 1'b0;
    cal_mask      = 2'b00;
    margin        = 4'd0;
    shift_gain_10 = 2'd0;
    DATA12_g01    = '0;
    valid_g01     = 1'b0;
    DATA12_g10    = '0;
    valid_g10     = 1'b0;
    repeat (3) step();
    @(negedge CLK);
    check_eq("rst_busy", cal_busy, 0);
    check_eq("rst_done", cal_done, 0);
    check_eq("rst_err", cal_err, 0);
    check_eq("rst_g01", BSL_VAL_g01, 0);
    check_eq("rst_g10", BSL_VAL_g10, 0);
    rst = 1'b0;
    step();

    // g01 only, constant 100, margin 2
    a01 = 100; b01v = 100; en01 = 1; en10 = 0; lim01 = -1;
    push_exp(N + 2, model_res(100, 2), 0, 0);
    kick(2'b01, 2, 0, 1);
    wait_idle(200, "t1");

    // both gains, g01 alternating 99/100 (mean 99), g10 800 >> 2
    a01 = 99; b01v = 100; en10 = 1; v10val = 800;
    push_exp(2 * N + 3, model_res((99 + 100) / 2, 4), model_res(800 / 4, 4), 0);
    kick(2'b11, 4, 2, 1);
    wait_idle(300, "t2");

    // g01 stalls after 10 samples: timeout keeps g01, g10 proceeds (400 >> 1)
    a01 = 100; b01v = 100; lim01 = 10; v10val = 400;
    push_exp(10 + TO + N + 2, 95, model_res(400 / 2, 3), 1);
    kick(2'b11, 3, 1, 1);
    wait_idle(1400, "t4");
    lim01 = -1;

    // saturation high
    a01 = 1000; b01v = 1000; en10 = 0;
    push_exp(N + 2, 255, 197, 1);
    kick(2'b01, 0, 0, 1);
    wait_idle(200, "t3a");

    // empty mask: immediate done, errors cleared, values kept
    push_exp(1, 255, 197, 0);
    kick(2'b00, 7, 0, 1);
    wait_idle(20, "t0");

    // mean below margin clamps to zero without error
    a01 = 3; b01v = 3;
    push_exp(N + 2, model_res(3, 5), 197, 0);
    kick(2'b01, 5, 0, 1);
    wait_idle(200, "t3b");

    // reset in the middle of ACC
    a01 = 100; b01v = 100; en10 = 1; v10val = 500;
    done_before = n_done;
    kick(2'b11, 1, 0, 1);
    repeat (30) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge CLK);
    check_eq("midrst_busy", cal_busy, 0);
    check_eq("midrst_g01", BSL_VAL_g01, 0);
    check_eq("midrst_g10", BSL_VAL_g10, 0);
    check_eq("midrst_err", cal_err, 0);
    repeat (200) step();
    check_eq("midrst_no_done", n_done, done_before);

    // cal_start while busy is ignored
    a01 = 50; b01v = 50; en10 = 0;
    done_before = n_done;
    push_exp(N + 2, model_res(50, 2), 0, 0);
    kick(2'b01, 2, 0, 1);
    repeat (20) step();
    kick(2'b10, 0, 0, 0);
    wait_idle(200, "t5");
    repeat (150) step();
    check_eq("busy_start_one_done", n_done - done_before, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ldtu_bsl_calib.md
# ldtu_bsl_calib

Automatic baseline calibration controller for the LiTe-DTU baseline-subtraction stage. On command, it measures the pedestal of the gain-1 and/or gain-10 ADC channels by averaging 2^NSAMP_LOG2 raw samples per channel. It then subtracts a safety margin, saturates the result to 8 bits and drives the per-gain baseline values consumed by the subtraction datapath. A single accumulator is time-shared between the two gains; calibration is sequenced g01 first, then g10.

## Interface
- Nbits_12, 12, raw ADC sample width
- Nbits_8, 8, baseline value width
- NSAMP_LOG2, 6, log2 of samples averaged per gain (legal 1..8)
- TIMEOUT, 1023, max cycles without an accepted sample before a gain is aborted

- CLK  in  1  LiTe-DTU clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- cal_start  in  1  calibration request, single-cycle pulse
- cal_mask  in  2  bit0 = calibrate g01, bit1 = calibrate g10; sampled with cal_start
- margin  in  4  offset subtracted from measured mean; sampled with cal_start
- shift_gain_10  in  2  right shift applied to g10 samples, same as the datapath; sampled with cal_start
- DATA12_g01  in  12  gain-1 raw sample
- valid_g01  in  1  DATA12_g01 valid this cycle
- DATA12_g10  in  12  gain-10 raw sample
- valid_g10  in  1  DATA12_g10 valid this cycle
- BSL_VAL_g01  out  8  baseline value for gain-1; reset 0
- BSL_VAL_g10  out  8  baseline value for gain-10; reset 0
- cal_busy  out  1  calibration in progress; reset 0
- cal_done  out  1  one-cycle pulse at end of calibration; reset 0
- cal_err  out  2  per-gain sticky error (saturation or timeout); bit0 g01, bit1 g10; reset 0

## Operation
- FSM states: IDLE, ACC, STORE, DONE; a gain-select register gsel (G01/G10) picks the sample source.
- IDLE:
  - cal_start=1 latches cal_mask, margin and shift_gain_10, and clears cal_err.
  - Mask 00 -> DONE. Otherwise -> ACC with gsel = lowest set mask bit.
  - Entering ACC clears the accumulator, sample counter and timeout counter.
- ACC:
  - Each cycle with the selected valid=1 adds the sample (g10 sample >> latched shift) and increments the sample counter.
  - After the 2^NSAMP_LOG2-th sample is accepted -> STORE.
  - A cycle without valid increments the timeout counter; any accepted sample resets it.
  - When the timeout counter reaches TIMEOUT with no valid in that cycle: set cal_err[gsel], leave BSL_VAL unchanged, then go to the next masked gain (ACC) or to DONE.
  - If valid and the timeout terminal count occur in the same cycle, valid wins.
- STORE:
  - mean = acc >> NSAMP_LOG2 (truncating).
  - If mean <= margin, result = 0 (no error). Otherwise result = mean - margin.
  - If result > 255, result = 255 and cal_err[gsel] is set.
  - The result is written to BSL_VAL of gsel. Next state is ACC for g10 if mask bit1 is set and gsel=G01; otherwise DONE.
- DONE: cal_done=1 for one cycle, then -> IDLE.
- cal_start while not in IDLE is ignored. Data and valid inputs are ignored outside ACC.
- rst at any point (including mid-ACC) returns to IDLE with all outputs at their reset values.
- The accumulator is Nbits_12+NSAMP_LOG2 bits wide and cannot overflow.

## Timing
- cal_start accepted in cycle 0. cal_busy is high from cycle 1 through the DONE cycle inclusive and low the following cycle.
- With continuous valid and N = 2^NSAMP_LOG2:
  - The g01 ACC state runs cycles 1..N; STORE is cycle N+1; BSL_VAL_g01 is updated from cycle N+2.
  - The g10 ACC state runs cycles N+2..2N+1; STORE is cycle 2N+2; DONE is cycle 2N+3.
- Single-gain mask: DONE at cycle N+2. Mask 00: DONE at cycle 1.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Package ldtu_bsl_pkg holds the FSM state enum, the gain-select encoding (G01=0, G10=1) and width constants (Nbits_12, Nbits_8, accumulator width function).
- Sub-module ldtu_bsl_accum contains the accumulator, sample counter and timeout counter. Its interface: clear, sample_in, sample_valid; outputs sum, count_full, timed_out.
- The top level holds the FSM, the input mux/shift, the mean/margin/saturation logic and the output registers.

## Test plan
- mask=01, margin=2, DATA12_g01 constant 100 with continuous valid -> BSL_VAL_g01=98 from cycle 66, BSL_VAL_g10 stays 0, cal_done at cycle 66, cal_err=00.
- mask=11, margin=4, shift=2, g01 alternating 99/100, g10 constant 800 -> BSL_VAL_g01=95 (mean 99), BSL_VAL_g10=196, cal_done at cycle 131.
- mask=01, g01 constant 1000, margin=0 -> BSL_VAL_g01=255, cal_err=01; g01 constant 3 with margin=5 -> BSL_VAL_g01=0, cal_err=00.
- mask=11, valid_g01 stops after 10 samples -> after 1023 idle cycles cal_err[0]=1 and BSL_VAL_g01 keeps its previous value; g10 then calibrates normally.
- rst asserted mid-ACC -> next cycle cal_busy=0, BSL_VAL_*=0, cal_err=0, no cal_done. A cal_start pulsed while busy -> ignored, exactly one cal_done.
